// File: rtl/led_display_scheduler_pkg.sv
// Shared types and constants for the LED display scheduler.
// The optional blank gap is enabled with the LED_SCHED_BLANK_EN macro.
package led_sched_pkg;

  localparam int BIN_W            = 4;
  localparam int HOLD_CYCLES_DEF  = 8;
  localparam int BLANK_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } sched_state_t;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_display_scheduler_if.sv
// Requester handshake and display bus between the value sources and the scheduler.
// Master is the source/display side, slave is the scheduler.
interface led_display_scheduler_if;
  import led_sched_pkg::*;

  logic [1:0]       reqValid;
  logic [BIN_W-1:0] reqData0;
  logic [BIN_W-1:0] reqData1;
  logic [1:0]       reqReady;
  logic [BIN_W-1:0] binNumber;
  logic             dispValid;
  logic             grantId;

  modport master (
    output reqValid, reqData0, reqData1,
    input  reqReady, binNumber, dispValid, grantId
  );

  modport slave (
    input  reqValid, reqData0, reqData1,
    output reqReady, binNumber, dispValid, grantId
  );

endinterface

// File: rtl/led_display_scheduler_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, on contention the one
// that was not granted last wins.
module rr_arbiter2 (
  input  logic [1:0] reqValid_i,
  input  logic       lastGrant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    case (reqValid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = lastGrant_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/led_display_scheduler.sv
// Time-multiplexes two 4-bit sources onto the LED binary display.
// Define LED_SCHED_BLANK_EN to insert a blank gap between consecutive values.
module led_display_scheduler
  import led_sched_pkg::*;
#(
  parameter int HOLD_CYCLES  = HOLD_CYCLES_DEF,
  parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
  input logic                    clock,
  input logic                    reset_n,
  led_display_scheduler_if.slave bus
);

  localparam int CNT_W = $clog2(maxInt(HOLD_CYCLES, BLANK_CYCLES) + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_SHOW = 2'(SHOW);
`ifdef LED_SCHED_BLANK_EN
  localparam logic [1:0] ST_BLANK = 2'(BLANK);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic             id_q, id_d;
  logic             last_q, last_d;
  logic [1:0]       grant;
  logic [1:0]       ready;
  logic             xfer;

  rr_arbiter2 u_arb (
    .reqValid_i  (bus.reqValid),
    .lastGrant_i (last_q),
    .grant_o     (grant)
  );

  // Ready is gated by reset_n so nothing is offered while reset is held.
  assign ready = ((state_q == ST_IDLE) && reset_n) ? grant : 2'b00;
  assign xfer  = |(ready & bus.reqValid);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    id_d    = id_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          bin_d   = ready[1] ? bus.reqData1 : bus.reqData0;
          id_d    = ready[1];
          last_d  = ready[1];
          cnt_d   = HOLD_LOAD;
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (cnt_q == '0) begin
`ifdef LED_SCHED_BLANK_EN
          state_d = ST_BLANK;
          cnt_d   = BLANK_LOAD;
          bin_d   = '0;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef LED_SCHED_BLANK_EN
      ST_BLANK: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // lastGrant resets to 1 so requester 0 has first priority.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign bus.reqReady  = ready;
  assign bus.binNumber = bin_q;
  assign bus.dispValid = (state_q == ST_SHOW);
  assign bus.grantId   = id_q;

endmodule

// File: tb/tb_led_display_scheduler.sv
// Scoreboard bench for led_display_scheduler: one DUT with HOLD_CYCLES=8, one with 1.
// Build with LED_SCHED_BLANK_EN defined to also exercise the blank gap.
module tb_led_display_scheduler;
  import led_sched_pkg::*;

  localparam int HOLD  = 8;
  localparam int BLANK = 2;
`ifdef LED_SCHED_BLANK_EN
  localparam int GAP = BLANK + 1;
`else
  localparam int GAP = 1;
`endif

  typedef struct {
    logic [3:0] data;
    logic       id;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  exp_t expQ[$];
  int   nCompared = 0;
  int   nMismatched = 0;
  logic modelLast = 1'b1;

  always #5 clock = ~clock;

  led_display_scheduler_if bus();
  led_display_scheduler_if bus1();

  led_display_scheduler #(.HOLD_CYCLES(HOLD), .BLANK_CYCLES(BLANK)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  led_display_scheduler #(.HOLD_CYCLES(1), .BLANK_CYCLES(BLANK)) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  task automatic applyStimulus(input bit which, input logic [1:0] v,
                               input logic [3:0] d0, input logic [3:0] d1);
    if (which) begin
      bus1.reqValid = v; bus1.reqData0 = d0; bus1.reqData1 = d1;
    end else begin
      bus.reqValid = v; bus.reqData0 = d0; bus.reqData1 = d1;
    end
    #1;
  endtask

  function automatic logic pickWinner(input logic [1:0] v);
    if (v == 2'b01) return 1'b0;
    if (v == 2'b10) return 1'b1;
    return ~modelLast;
  endfunction

  function automatic exp_t popExp();
    exp_t e;
    e.data = 4'bxxxx;
    e.id   = 1'bx;
    if (expQ.size() != 0) e = expQ.pop_front();
    return e;
  endfunction

  // Waits (bounded) for a display to start, then measures how long it lasts.
  task automatic waitShow(input bit which, output logic [3:0] bin, output logic id,
                          output int waitC, output int len);
    waitC = 0;
    while (((which ? bus1.dispValid : bus.dispValid) !== 1'b1) && waitC < 60) begin
      cyc();
      waitC++;
    end
    bin = which ? bus1.binNumber : bus.binNumber;
    id  = which ? bus1.grantId : bus.grantId;
    len = 0;
    while (((which ? bus1.dispValid : bus.dispValid) === 1'b1) && len < 60) begin
      len++;
      cyc();
    end
  endtask

  task automatic test_reset();
    logic [3:0] bin; logic id; int waitC, len; exp_t e;
    reset_n = 1'b0;
    applyStimulus(1'b1, 2'b00, 4'h0, 4'h0);
    applyStimulus(1'b0, 2'b11, 4'h9, 4'h6);
    repeat (3) cyc();
    nCompared++;
    if (bus.binNumber !== 4'h0) begin nMismatched++; $display("[TB] FAIL reset_bin: got %b want 0000", bus.binNumber); end
    nCompared++;
    if (bus.dispValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_disp: got %b want 0", bus.dispValid); end
    nCompared++;
    if (bus.grantId !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_id: got %b want 0", bus.grantId); end
    nCompared++;
    if (bus.reqReady !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_ready: got %b want 00", bus.reqReady); end
    modelLast = 1'b1;
    reset_n = 1'b1;
    #1;
    nCompared++;
    if (bus.reqReady !== (pickWinner(2'b11) ? 2'b10 : 2'b01)) begin
      nMismatched++; $display("[TB] FAIL first_grant: got %b want 01", bus.reqReady);
    end
    expQ.push_back('{4'h9, pickWinner(2'b11)});
    modelLast = pickWinner(2'b11);
    cyc();
    applyStimulus(1'b0, 2'b00, 4'h9, 4'h6);
    waitShow(1'b0, bin, id, waitC, len);
    e = popExp();
    nCompared++;
    if (bin !== e.data) begin nMismatched++; $display("[TB] FAIL reset_first_bin: got %b want %b", bin, e.data); end
    nCompared++;
    if (id !== e.id) begin nMismatched++; $display("[TB] FAIL reset_first_id: got %b want %b", id, e.id); end
    nCompared++;
    if (len != HOLD) begin nMismatched++; $display("[TB] FAIL reset_first_len: got %0d want %0d", len, HOLD); end
    repeat (GAP) cyc();
  endtask

  task automatic test_single();
    logic [3:0] bin; logic id; int waitC, len; exp_t e;
    applyStimulus(1'b0, 2'b01, 4'b1010, 4'b0000);
    nCompared++;
    if (bus.reqReady !== 2'b01) begin nMismatched++; $display("[TB] FAIL single_ready: got %b want 01", bus.reqReady); end
    expQ.push_back('{4'b1010, 1'b0});
    modelLast = 1'b0;
    cyc();
    applyStimulus(1'b0, 2'b00, 4'b1010, 4'b0000);
    nCompared++;
    if (bus.reqReady !== 2'b00) begin nMismatched++; $display("[TB] FAIL single_ready_show: got %b want 00", bus.reqReady); end
    waitShow(1'b0, bin, id, waitC, len);
    e = popExp();
    nCompared++;
    if (bin !== e.data) begin nMismatched++; $display("[TB] FAIL single_bin: got %b want %b", bin, e.data); end
    nCompared++;
    if (id !== e.id) begin nMismatched++; $display("[TB] FAIL single_id: got %b want %b", id, e.id); end
    nCompared++;
    if (len != HOLD) begin nMismatched++; $display("[TB] FAIL single_len: got %0d want %0d", len, HOLD); end
    repeat (GAP) cyc();
  endtask

  task automatic test_contention();
    logic [3:0] bin; logic id; int waitC, len; exp_t e; logic w;
    applyStimulus(1'b0, 2'b11, 4'b0111, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      w = pickWinner(2'b11);
      expQ.push_back('{(w ? 4'b0001 : 4'b0111), w});
      modelLast = w;
    end
    for (int k = 0; k < 3; k++) begin
      waitShow(1'b0, bin, id, waitC, len);
      if (k == 2) applyStimulus(1'b0, 2'b00, 4'b0111, 4'b0001);
      e = popExp();
      nCompared++;
      if (bin !== e.data) begin nMismatched++; $display("[TB] FAIL contention_bin[%0d]: got %b want %b", k, bin, e.data); end
      nCompared++;
      if (id !== e.id) begin nMismatched++; $display("[TB] FAIL contention_id[%0d]: got %b want %b", k, id, e.id); end
      nCompared++;
      if (len != HOLD) begin nMismatched++; $display("[TB] FAIL contention_len[%0d]: got %0d want %0d", k, len, HOLD); end
      if (k > 0) begin
        nCompared++;
        if (waitC != GAP) begin nMismatched++; $display("[TB] FAIL contention_gap[%0d]: got %0d want %0d", k, waitC, GAP); end
      end
    end
    repeat (GAP) cyc();
  endtask

  task automatic test_reset_mid();
    applyStimulus(1'b0, 2'b01, 4'b0101, 4'b0000);
    expQ.push_back('{4'b0101, 1'b0});
    cyc();
    applyStimulus(1'b0, 2'b00, 4'b0101, 4'b0000);
    repeat (3) cyc();
    reset_n = 1'b0;
    cyc();
    expQ.delete();
    nCompared++;
    if (bus.dispValid !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_disp: got %b want 0", bus.dispValid); end
    nCompared++;
    if (bus.binNumber !== 4'h0) begin nMismatched++; $display("[TB] FAIL mid_bin: got %b want 0000", bus.binNumber); end
    nCompared++;
    if (bus.grantId !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_id: got %b want 0", bus.grantId); end
    nCompared++;
    if (bus.reqReady !== 2'b00) begin nMismatched++; $display("[TB] FAIL mid_ready: got %b want 00", bus.reqReady); end
    reset_n = 1'b1;
    modelLast = 1'b1;
    applyStimulus(1'b0, 2'b01, 4'b0101, 4'b0000);
    nCompared++;
    if (bus.reqReady !== 2'b01) begin nMismatched++; $display("[TB] FAIL mid_idle_ready: got %b want 01", bus.reqReady); end
    applyStimulus(1'b0, 2'b00, 4'b0101, 4'b0000);
    cyc();
  endtask

  task automatic test_hold1();
    logic [3:0] bin; logic id; int waitC, len; exp_t e;
    applyStimulus(1'b1, 2'b10, 4'b0000, 4'b0011);
    expQ.push_back('{4'b0011, 1'b1});
    expQ.push_back('{4'b0011, 1'b1});
    for (int k = 0; k < 2; k++) begin
      waitShow(1'b1, bin, id, waitC, len);
      if (k == 1) applyStimulus(1'b1, 2'b00, 4'b0000, 4'b0011);
      e = popExp();
      nCompared++;
      if (bin !== e.data) begin nMismatched++; $display("[TB] FAIL hold1_bin[%0d]: got %b want %b", k, bin, e.data); end
      nCompared++;
      if (id !== e.id) begin nMismatched++; $display("[TB] FAIL hold1_id[%0d]: got %b want %b", k, id, e.id); end
      nCompared++;
      if (len != 1) begin nMismatched++; $display("[TB] FAIL hold1_len[%0d]: got %0d want 1", k, len); end
      if (k == 1) begin
        nCompared++;
        if (waitC != GAP) begin nMismatched++; $display("[TB] FAIL hold1_gap: got %0d want %0d", waitC, GAP); end
      end
    end
    repeat (GAP) cyc();
  endtask

`ifdef LED_SCHED_BLANK_EN
  task automatic test_blank();
    logic [3:0] bin; logic id; int waitC, len, gapLen; exp_t e;
    applyStimulus(1'b0, 2'b01, 4'b1111, 4'b0000);
    expQ.push_back('{4'b1111, 1'b0});
    expQ.push_back('{4'b1111, 1'b0});
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin
        gapLen = 0;
        while (bus.dispValid !== 1'b1 && gapLen < 20) begin
          nCompared++;
          if (bus.binNumber !== 4'h0) begin nMismatched++; $display("[TB] FAIL blank_bin[%0d]: got %b want 0000", gapLen, bus.binNumber); end
          gapLen++;
          cyc();
        end
        nCompared++;
        if (gapLen != BLANK + 1) begin nMismatched++; $display("[TB] FAIL blank_gap: got %0d want %0d", gapLen, BLANK + 1); end
      end
      waitShow(1'b0, bin, id, waitC, len);
      if (k == 1) applyStimulus(1'b0, 2'b00, 4'b1111, 4'b0000);
      e = popExp();
      nCompared++;
      if (bin !== e.data) begin nMismatched++; $display("[TB] FAIL blank_show_bin[%0d]: got %b want %b", k, bin, e.data); end
      nCompared++;
      if (len != HOLD) begin nMismatched++; $display("[TB] FAIL blank_show_len[%0d]: got %0d want %0d", k, len, HOLD); end
    end
    repeat (GAP) cyc();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_reset_mid();
    test_hold1();
`ifdef LED_SCHED_BLANK_EN
    test_blank();
`endif
    nCompared++;
    if (expQ.size() != 0) begin nMismatched++; $display("[TB] FAIL scoreboard_leftover: got %0d want 0", expQ.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
